// File: rtl/fft_pkg.sv
// Shared widths and constants for the parallel-4 FFT datapath.
// The twiddle format is Q2.14, so both +1.0 and -1.0 can be represented.
package fft_pkg;

  localparam int NB_DATA  = 20;
  localparam int NB_TW    = 16;
  localparam int NBF_TW   = 14;
  localparam int NB_PROD  = NB_DATA + NB_TW;
  localparam int NB_SUM   = NB_PROD + 1;
  localparam int RND_HALF = 1 << (NBF_TW - 1);
  localparam int TW_ONE   = 16384;

endpackage

// File: rtl/rnd_shift.sv
// Round-half-up scaling of one rail: S3 adds half an LSB, and S4 keeps the
// floor-shifted output window.
module rnd_shift #(
  parameter int W   = fft_pkg::NB_SUM,
  parameter int NBF = fft_pkg::NBF_TW,
  parameter int NO  = fft_pkg::NB_DATA + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] sum,
  output logic signed [NO-1:0] res
);

  localparam logic signed [W-1:0] HALF = W'(64'sd1 << (NBF - 1));

  logic signed [W-1:0]  sum_p3;
  logic signed [NO-1:0] rnd_p4;

  // Adding half an output LSB before a floor shift rounds ties toward +inf.
  function automatic logic signed [W-1:0] add_half(input logic signed [W-1:0] v);
    return v + HALF;
  endfunction

  // S3: half-LSB bias
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p3 <= '0;
    end else if (en) begin
      sum_p3 <= add_half(sum);
    end
  end

  // S4: the arithmetic shift right, truncated to NO bits, is a plain bit window.
  // Bits above the window only matter for out-of-range twiddles, which wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_p4 <= '0;
    end else if (en) begin
      rnd_p4 <= sum_p3[NBF+NO-1:NBF];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sum_p3[NBF-1:0], sum_p3[W-1:NBF+NO]};

  assign res = rnd_p4;

endmodule

// File: rtl/cmult_rnd.sv
// Pipelined complex multiplier (a+jb)(c+jd) with a Q2.14 twiddle and round-half-up
// scaling. Latency is 4 enabled cycles, and valid/last travel alongside the data.
module cmult_rnd #(
  parameter int NB_DATA = fft_pkg::NB_DATA,
  parameter int NB_TW   = fft_pkg::NB_TW,
  parameter int NBF_TW  = fft_pkg::NBF_TW,
  parameter int NB_OUT  = NB_DATA + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic                      i_last,
  input  logic signed [NB_DATA-1:0] i_re,
  input  logic signed [NB_DATA-1:0] i_im,
  input  logic signed [NB_TW-1:0]   i_tw_re,
  input  logic signed [NB_TW-1:0]   i_tw_im,
  output logic                      o_valid,
  output logic                      o_last,
  output logic signed [NB_OUT-1:0]  o_re,
  output logic signed [NB_OUT-1:0]  o_im
);

  import fft_pkg::*;

  localparam int PROD_W = NB_DATA + NB_TW;
  localparam int SUM_W  = PROD_W + 1;

  logic signed [NB_DATA-1:0] a_p1, b_p1;
  logic signed [NB_TW-1:0]   c_p1, d_p1;
  logic signed [PROD_W-1:0]  ac_p2, bd_p2, ad_p2, bc_p2;
  logic signed [SUM_W-1:0]   re_sum, im_sum;
  logic                      vld_p1, vld_p2, vld_p3, vld_p4;
  logic                      last_p1, last_p2, last_p3, last_p4;

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [NB_DATA-1:0] x,
                                                   input logic signed [NB_TW-1:0]   y);
    return PROD_W'(x) * PROD_W'(y);
  endfunction

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1 <= '0;
      b_p1 <= '0;
      c_p1 <= '0;
      d_p1 <= '0;
    end else if (i_enable) begin
      a_p1 <= i_re;
      b_p1 <= i_im;
      c_p1 <= i_tw_re;
      d_p1 <= i_tw_im;
    end
  end

  // S2: full-precision partial products
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_p2 <= '0;
      bd_p2 <= '0;
      ad_p2 <= '0;
      bc_p2 <= '0;
    end else if (i_enable) begin
      ac_p2 <= mul(a_p1, c_p1);
      bd_p2 <= mul(b_p1, d_p1);
      ad_p2 <= mul(a_p1, d_p1);
      bc_p2 <= mul(b_p1, c_p1);
    end
  end

  // The sum is one bit wider than a product, so the add cannot overflow.
  assign re_sum = SUM_W'(ac_p2) - SUM_W'(bd_p2);
  assign im_sum = SUM_W'(ad_p2) + SUM_W'(bc_p2);

  // S3/S4: rounding and output-window selection, one instance per rail
  rnd_shift #(
    .W   (SUM_W),
    .NBF (NBF_TW),
    .NO  (NB_OUT)
  ) u_rnd_re (
    .clk (clk),
    .rst (rst),
    .en  (i_enable),
    .sum (re_sum),
    .res (o_re)
  );

  rnd_shift #(
    .W   (SUM_W),
    .NBF (NBF_TW),
    .NO  (NB_OUT)
  ) u_rnd_im (
    .clk (clk),
    .rst (rst),
    .en  (i_enable),
    .sum (im_sum),
    .res (o_im)
  );

  // Sideband: a 4-deep shift that stays aligned with S1..S4
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
      last_p3 <= 1'b0;
      last_p4 <= 1'b0;
    end else if (i_enable) begin
      vld_p1  <= i_valid;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      vld_p4  <= vld_p3;
      last_p1 <= i_last;
      last_p2 <= last_p1;
      last_p3 <= last_p2;
      last_p4 <= last_p3;
    end
  end

  assign o_valid = vld_p4;
  assign o_last  = last_p4;

endmodule

// File: tb/tb_cmult_rnd.sv
// Self-checking bench for cmult_rnd: table vectors, stall and reset sequences,
// and a randomized run against an enabled-cycle history model.
module tb_cmult_rnd;

  logic clk = 1'b0;
  logic rst;
  logic i_enable;
  logic i_valid;
  logic i_last;
  logic signed [19:0] i_re, i_im;
  logic signed [15:0] i_tw_re, i_tw_im;
  logic o_valid, o_last;
  logic signed [20:0] o_re, o_im;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmult_rnd dut (
    .clk     (clk),
    .rst     (rst),
    .i_enable(i_enable),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_re    (i_re),
    .i_im    (i_im),
    .i_tw_re (i_tw_re),
    .i_tw_im (i_tw_im),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_re    (o_re),
    .o_im    (o_im)
  );

  // Model: the output reflects whatever was presented 4 enabled edges ago,
  // or zero if fewer than 4 enabled edges have occurred since reset.
  typedef struct {
    bit     vld;
    bit     last;
    longint a, b, c, d;
  } smp_t;

  smp_t hist[$];

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
    end else if (i_enable) begin
      hist.push_back('{i_valid, i_last, i_re, i_im, i_tw_re, i_tw_im});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  function automatic longint rnd_ref(longint p);
    longint s;
    logic signed [20:0] w;
    s = (p + 8192) >>> 14;
    w = s[20:0];
    return longint'(w);
  endfunction

  task automatic check(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(string nm);
    smp_t e;
    longint er = 0, ei = 0;
    bit ev = 0, el = 0;
    if (hist.size() >= 4) begin
      e  = hist[hist.size() - 4];
      ev = e.vld;
      el = e.last;
      er = rnd_ref(e.a * e.c - e.b * e.d);
      ei = rnd_ref(e.a * e.d + e.b * e.c);
    end
    check({nm, ".valid"}, longint'(o_valid), longint'(ev));
    check({nm, ".last"},  longint'(o_last),  longint'(el));
    check({nm, ".re"},    longint'(o_re),    er);
    check({nm, ".im"},    longint'(o_im),    ei);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit l, longint a, longint b, longint c, longint d);
    i_valid = v;
    i_last  = l;
    i_re    = 20'(a);
    i_im    = 20'(b);
    i_tw_re = 16'(c);
    i_tw_im = 16'(d);
  endtask

  typedef struct {
    string  nm;
    longint a, b, c, d, er, ei;
  } vec_t;

  vec_t vt[9];

  typedef struct {
    longint re, im;
    bit     last;
  } res_t;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    longint sa[6], sb[6], sc[6], sd[6];
    res_t got[$];
    res_t r;
    logic signed [20:0] prev_re, prev_im;
    logic prev_v, prev_l;
    int sidx, n;
    bit en;

    vt[0] = '{"identity",  1000,    -250,    16384,  0,      1000,    -250};
    vt[1] = '{"rnd_pos",   1,       0,       8192,   0,      1,       0};
    vt[2] = '{"rnd_neg",   -1,      0,       8192,   0,      0,       0};
    vt[3] = '{"rnd_three", 3,       0,       8192,   0,      2,       0};
    vt[4] = '{"rnd_mthree",-3,      0,       8192,   0,      -1,      0};
    vt[5] = '{"growth",    524287,  524287,  11585,  11585,  0,       741439};
    vt[6] = '{"min_edge",  -524288, 0,       16384,  0,      -524288, 0};
    vt[7] = '{"min_neg",   -524288, 0,       -16384, 0,      524288,  0};
    vt[8] = '{"wrap",      -524288, -524288, -16384, -16384, 0,       -1048576};

    // Reset state
    rst = 1'b1;
    i_enable = 1'b1;
    drive(1, 1, 5, 6, 7, 8);
    repeat (3) tick();
    check("reset.valid", longint'(o_valid), 0);
    check("reset.last",  longint'(o_last),  0);
    check("reset.re",    longint'(o_re),    0);
    check("reset.im",    longint'(o_im),    0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // Table vectors: single valid pulse, result after exactly 4 enabled edges
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, vt[i].a, vt[i].b, vt[i].c, vt[i].d);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check({vt[i].nm, ".early"}, longint'(o_valid), 0);
      tick();
      check({vt[i].nm, ".valid"}, longint'(o_valid), 1);
      check({vt[i].nm, ".re"},    longint'(o_re),    vt[i].er);
      check({vt[i].nm, ".im"},    longint'(o_im),    vt[i].ei);
      tick();
      check({vt[i].nm, ".drop"},  longint'(o_valid), 0);
    end

    // Stall: 6 samples, last on the 6th, enable low for 3 cycles mid-stream
    for (int i = 0; i < 6; i++) begin
      sa[i] = longint'($signed(20'($urandom)));
      sb[i] = longint'($signed(20'($urandom)));
      sc[i] = longint'($signed(16'($urandom_range(0, 32767) - 16384)));
      sd[i] = longint'($signed(16'($urandom_range(0, 32767) - 16384)));
    end
    sidx = 0;
    for (int k = 0; k < 20; k++) begin
      en = !(k >= 5 && k <= 7);
      i_enable = en;
      if (en && sidx < 6) begin
        drive(1, sidx == 5, sa[sidx], sb[sidx], sc[sidx], sd[sidx]);
        sidx++;
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      if (en && o_valid) got.push_back('{longint'(o_re), longint'(o_im), o_last});
      prev_re = o_re;
      prev_im = o_im;
      prev_v  = o_valid;
      prev_l  = o_last;
      tick();
      if (!en) begin
        check("stall.hold_valid", longint'(o_valid), longint'(prev_v));
        check("stall.hold_last",  longint'(o_last),  longint'(prev_l));
        check("stall.hold_re",    longint'(o_re),    longint'(prev_re));
        check("stall.hold_im",    longint'(o_im),    longint'(prev_im));
      end
      check_model("stall.model");
    end
    i_enable = 1'b1;
    check("stall.count", longint'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      r = got[i];
      check("stall.re",   r.re, rnd_ref(sa[i] * sc[i] - sb[i] * sd[i]));
      check("stall.im",   r.im, rnd_ref(sa[i] * sd[i] + sb[i] * sc[i]));
      check("stall.last", longint'(r.last), longint'(i == 5));
    end

    // Reset mid-operation: 3 samples in flight, then a 1-cycle reset
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 100 + i, 200, 16384, 0);
      tick();
    end
    rst = 1'b1;
    drive(1, 1, 777, 0, 16384, 0);
    tick();
    rst = 1'b0;
    check("rstmid.valid", longint'(o_valid), 0);
    check("rstmid.last",  longint'(o_last),  0);
    check("rstmid.re",    longint'(o_re),    0);
    check("rstmid.im",    longint'(o_im),    0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rstmid.no_stale", longint'(o_valid), 0);
    end
    drive(1, 1, -4321, 1234, 16384, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n = 1;
    while (!o_valid && n < 10) begin
      tick();
      n++;
    end
    check("rstmid.latency", longint'(n), 4);
    check("rstmid.re",      longint'(o_re),   -4321);
    check("rstmid.im",      longint'(o_im),   1234);
    check("rstmid.last1",   longint'(o_last), 1);

    // Reset wins even with enable low
    drive(1, 1, 55, 66, 16384, 0);
    repeat (4) tick();
    rst = 1'b1;
    i_enable = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_noen.valid", longint'(o_valid), 0);
    check("rst_noen.re",    longint'(o_re),    0);
    check("rst_noen.im",    longint'(o_im),    0);
    i_enable = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Randomized run against the history model
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 63) == 0);
      i_enable = ($urandom_range(0, 4) != 0);
      i_valid  = $urandom_range(0, 1) == 1;
      i_last   = ($urandom_range(0, 4) == 0);
      i_re     = 20'($urandom);
      i_im     = 20'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        i_tw_re = 16'($urandom_range(0, 32768) - 16384);
        i_tw_im = 16'($urandom_range(0, 32768) - 16384);
      end else begin
        i_tw_re = 16'($urandom);
        i_tw_im = 16'($urandom);
      end
      tick();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
